mem_stream_dma: RTL and testbench

MEM_STREAM_DMA -- requirements
Module: mem_stream_dma

---
 rtl/mem_stream_dma_pkg.sv | 7 +
 rtl/mem_stream_dma_if.sv | 30 +++
 rtl/mem_stream_dma_stream_out_reg.sv | 24 ++
 rtl/mem_stream_dma.sv | 88 ++++++++
 tb/tb_mem_stream_dma.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mem_stream_dma_pkg.sv
// mem_stream_dma_pkg: shared defaults, FSM states and transfer limit for the DMA block
package mem_stream_dma_pkg;
    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 34;
    localparam int MAX_LEN = 128;
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
endpackage

// File: rtl/mem_stream_dma_if.sv
// mem_stream_dma_if: control, memory and stream signals between the DMA and its host side
interface mem_stream_dma_if #(
    parameter int ADDR_W = mem_stream_dma_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_stream_dma_pkg::DATA_W_DEF
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        length;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              busy;
    logic              done;
    modport dma (
        input  start, mode, base_addr, length, mem_read_data, out_ready, in_valid, in_data,
        output mem_address, mem_write_enable, mem_write_data, out_valid, out_data, in_ready, busy, done
    );
    modport host (
        output start, mode, base_addr, length, mem_read_data, out_ready, in_valid, in_data,
        input  mem_address, mem_write_enable, mem_write_data, out_valid, out_data, in_ready, busy, done
    );
endinterface

// File: rtl/mem_stream_dma_stream_out_reg.sv
// stream_out_reg: one-entry valid/ready holding register for the read stream
module stream_out_reg #(
    parameter int DATA_W = mem_stream_dma_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_stream_dma.sv
// mem_stream_dma: moves up to 128 words between a combinational-read memory and valid/ready streams
module mem_stream_dma
    import mem_stream_dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic             clk,
    input logic             rst,
    mem_stream_dma_if.dma   bus
);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        remaining;
    logic              busy;
    logic              done;
    logic              load;
    logic              we;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    // refill the holding register whenever it is empty or being drained this cycle
    assign load = state == RD && remaining != 8'd0 && (!out_valid || bus.out_ready);
    assign we   = state == WR && remaining != 8'd0 && bus.in_valid;
    assign bus.mem_address      = (state == RD || state == WR) ? cur_addr : '0;
    assign bus.mem_write_enable = we;
    assign bus.mem_write_data   = we ? bus.in_data : '0;
    assign bus.in_ready         = state == WR && remaining != 8'd0;
    assign bus.out_valid        = out_valid;
    assign bus.out_data         = out_data;
    assign bus.busy             = busy;
    assign bus.done             = done;
    stream_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (bus.mem_read_data),
        .ready     (bus.out_ready),
        .valid     (out_valid),
        .data      (out_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    cur_addr  <= bus.base_addr;
                    remaining <= bus.length > MAX_LEN_B ? MAX_LEN_B : bus.length;
                    busy      <= 1'b1;
                    if (bus.length == 8'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= bus.mode ? WR : RD;
                    end
                end
                RD: begin
                    if (load) begin
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        remaining <= remaining - 8'd1;
                    end
                    if (remaining == 8'd0 && out_valid && bus.out_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WR: if (we) begin
                    cur_addr  <= cur_addr + ADDR_W'(1);
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stream_dma.sv
// tb_mem_stream_dma: directed and randomized transfers against a queue/array model of the memory
module tb_mem_stream_dma;
    localparam int AW = 7;
    localparam int DW = 34;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b0;
    always #5 clk = ~clk;
    mem_stream_dma_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    mem_stream_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [DW-1:0] mem [128];
    logic [DW-1:0] ref_mem [128];
    always @(posedge clk) begin
        if (preload) for (int i = 0; i < 128; i++) mem[i] <= DW'(i);
        else if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;
    end
    assign bus.mem_read_data = mem[bus.mem_address];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int compared = 0;
    int failed = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fixed_q[$];
    int beat_cyc[$];
    int s0 = 0, beats = 0, writes = 0, done_cnt = 0, done_cyc = -1, busy_cnt = 0, widx = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [DW-1:0] pd = '0;
    // passive monitor: scoreboard for read beats plus per-cycle protocol rules
    always @(negedge clk) begin
        if (rst) pv = 1'b0;
        else begin
            if (bus.out_valid && bus.out_ready) begin
                beats++;
                beat_cyc.push_back(cyc - s0);
                if (exp_q.size() != 0) chk("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
            end
            if (bus.in_valid && bus.in_ready) widx++;
            if (bus.mem_write_enable) writes++;
            if (bus.done) begin done_cnt++; done_cyc = cyc - s0; end
            if (bus.busy) busy_cnt++;
            chk("wdata_zero", 64'(bus.mem_write_enable | (bus.mem_write_data == '0)), 64'd1);
            if (pv && !pr) chk("out_hold", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, pd}));
            if (!bus.busy) chk("idle_quiet", 64'({bus.mem_address, bus.in_ready, bus.mem_write_enable, bus.out_valid}), 64'd0);
            pv = bus.out_valid;
            pr = bus.out_ready;
            pd = bus.out_data;
        end
    end
    function automatic int bc(input int i);
        return i < beat_cyc.size() ? beat_cyc[i] : -1;
    endfunction
    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction
    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 64'({bus.busy, bus.done, bus.out_valid, bus.mem_address, bus.mem_write_enable, bus.in_ready}), 64'd0);
        chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
        chk({tag, "_wdata"}, 64'(bus.mem_write_data), 64'd0);
    endtask
    task automatic check_mem(input string tag);
        int diff = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk({tag, "_mem"}, 64'(diff), 64'd0);
    endtask
    task automatic run(input bit m, input int base, input int len, input int pct, input int lo, input int hi, input string tag);
        int n = len > 128 ? 128 : len;
        logic [DW-1:0] wd[$];
        exp_q.delete();
        beat_cyc.delete();
        beats = 0; writes = 0; done_cnt = 0; busy_cnt = 0; widx = 0; done_cyc = -1;
        for (int i = 0; i < n; i++) begin
            int a = (base + i) % 128;
            if (m) begin
                logic [DW-1:0] d = fixed_q.size() != 0 ? fixed_q.pop_front() : rnd_word();
                wd.push_back(d);
                ref_mem[a] = d;
            end else exp_q.push_back(ref_mem[a]);
        end
        bus.start = 1'b1;
        bus.mode = m;
        bus.base_addr = AW'(base);
        bus.length = 8'(len);
        s0 = cyc;
        for (int k = 0; k < 4000 && !(done_cnt > 0 && !bus.busy); k++) begin
            int c = cyc - s0;
            bus.out_ready = (c >= lo && c <= hi) ? 1'b0 : ($urandom_range(99) < pct);
            bus.in_valid = $urandom_range(99) < pct;
            bus.in_data = widx < wd.size() ? wd[widx] : rnd_word();
            @(posedge clk);
            #1;
            // start and parameters wiggle while busy; they must have no effect
            bus.start = bus.busy ? 1'($urandom_range(1)) : 1'b0;
            bus.mode = 1'($urandom_range(1));
            bus.base_addr = AW'($urandom_range(127));
            bus.length = 8'($urandom_range(255));
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, "_beats"}, 64'(beats), 64'(m ? 0 : n));
        chk({tag, "_writes"}, 64'(writes), 64'(m ? n : 0));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(done_cyc));
        chk({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
        check_mem(tag);
    endtask
    initial begin
        logic [DW-1:0] w6[4];
        bus.start = 1'b0; bus.mode = 1'b0; bus.base_addr = '0; bus.length = '0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = DW'(i);
        preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        run(1'b0, 5, 3, 100, 1, 0, "b1");
        chk("b1_beat_cycles", 64'({8'(bc(0)), 8'(bc(1)), 8'(bc(2))}), 64'({8'd2, 8'd3, 8'd4}));
        chk("b1_done_cycle", 64'(done_cyc), 64'd5);
        run(1'b0, 5, 3, 100, 2, 4, "b2");
        chk("b2_beat_cycles", 64'({8'(bc(0)), 8'(bc(1)), 8'(bc(2))}), 64'({8'd5, 8'd6, 8'd7}));
        chk("b2_done_cycle", 64'(done_cyc), 64'd8);
        fixed_q = '{34'h3FFFFFFFF, 34'h1, 34'h2, 34'h3};
        run(1'b1, 126, 4, 100, 1, 0, "b3");
        chk("b3_done_cycle", 64'(done_cyc), 64'd5);
        run(1'b0, 9, 0, 100, 1, 0, "b4r");
        chk("b4r_done_cycle", 64'(done_cyc), 64'd1);
        run(1'b1, 9, 0, 100, 1, 0, "b4w");
        chk("b4w_done_cycle", 64'(done_cyc), 64'd1);
        run(1'b0, 100, 200, 100, 1, 0, "b5");
        run(1'b1, 60, 255, 70, 1, 0, "b5w");
        for (int i = 0; i < 4; i++) w6[i] = rnd_word();
        done_cnt = 0;
        s0 = cyc;
        bus.start = 1'b1; bus.mode = 1'b1; bus.base_addr = 7'd10; bus.length = 8'd4;
        bus.in_valid = 1'b1; bus.in_data = w6[0];
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.in_data = w6[0];
        @(posedge clk);
        #1;
        bus.in_data = w6[1];
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("b6_abort");
        ref_mem[10] = w6[0];
        ref_mem[11] = w6[1];
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b6_no_done", 64'(done_cnt), 64'd0);
        check_mem("b6_abort");
        run(1'b0, 10, 2, 100, 1, 0, "b6_after");
        for (int t = 0; t < 10; t++) begin
            bit m = 1'($urandom_range(1));
            int len = $urandom_range(3) == 0 ? $urandom_range(129, 255) : $urandom_range(0, 40);
            run(m, $urandom_range(127), len, $urandom_range(30, 100), 1, 0, $sformatf("rnd%0d", t));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
